diff_event_sender: RTL and testbench

- Upstream transmit stage for the differential-pair decoder.
- Converts single-cycle event pulses into a 4-phase level handshake on a differential output pair (diff_po/diff_no).
- Each transfer completes only when the far side returns a differentially encoded acknowledge pair.
- Queues bursts in a saturating pending counter and flags signal-integrity faults on the returning ack pair.

---
 rtl/diff_event_sender.sv | 149 ++++++++++++++
 tb/tb_diff_event_sender.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_event_sender.sv
// Transmit side of a differential-pair event link: each event becomes a 4-phase
// level handshake on diff_po/diff_no, acknowledged by a differentially encoded ack pair.
module diff_event_sender #(
    parameter bit AsyncOn = 1'b0,
    parameter int MaxPend = 15
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         event_i,
    input  logic                         ack_pi,
    input  logic                         ack_ni,
    output logic                         diff_po,
    output logic                         diff_no,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(MaxPend+1)-1:0] pend_o,
    output logic                         ovf_o,
    output logic                         ack_sigint_o
);
    localparam int PendW = $clog2(MaxPend + 1);
    localparam logic [PendW-1:0] PendMax = PendW'(MaxPend);

    typedef enum logic [1:0] {
        Idle,
        Assert,
        Deassert
    } state_e;

    logic ack_p;
    logic ack_n;

    generate
        if (AsyncOn) begin : g_sync
            logic [1:0] sync_p_q;
            logic [1:0] sync_n_q;
            // Sync flops reset to the idle ack encoding so no spurious fault is seen.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_p_q <= 2'b00;
                    sync_n_q <= 2'b11;
                end else begin
                    // NOTE: non-blocking here so both stages sample the pre-edge values and form a real 2-flop chain.
                    sync_p_q <= {sync_p_q[0], ack_pi};
                    sync_n_q <= {sync_n_q[0], ack_ni};
                end
            end
            assign ack_p = sync_p_q[1];
            assign ack_n = sync_n_q[1];
        end else begin : g_direct
            assign ack_p = ack_pi;
            assign ack_n = ack_ni;
        end
    endgenerate

    logic ack_ok;
    logic ack_lvl;
    assign ack_ok  = ack_p ^ ack_n;
    assign ack_lvl = ack_p;

    state_e           state_q, state_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             sigint_q, sigint_d;
    logic             bad_q;
    logic             diff_p_q;
    logic             diff_n_q;
    logic             advance;
    logic             start;
    logic             inc;
    logic             dec;

    // With the synchronizer a single bad sample is tolerated as skew between the wires.
    always_comb begin
        if (AsyncOn) sigint_d = ~ack_ok & bad_q;
        else         sigint_d = ~ack_ok;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        start   = 1'b0;
        advance = ack_ok & ~sigint_q;

        case (state_q)
            Idle: begin
                if (advance && !ack_lvl && (event_i || pend_q != '0)) begin
                    start   = 1'b1;
                    state_d = Assert;
                end
            end
            Assert: begin
                if (advance && ack_lvl) state_d = Deassert;
            end
            Deassert: begin
                if (advance && !ack_lvl) begin
                    state_d = Idle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase

        // An event that starts a transfer straight from an empty queue never enters it.
        inc = event_i & ~(start & (pend_q == '0));
        dec = start & (pend_q != '0);

        if (inc && !dec) begin
            if (pend_q == PendMax) ovf_d = 1'b1;
            else                   pend_d = pend_q + PendW'(1);
        end else if (dec && !inc) begin
            pend_d = pend_q - PendW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            pend_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sigint_q <= 1'b0;
            bad_q    <= 1'b0;
            diff_p_q <= 1'b0;
            diff_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            sigint_q <= sigint_d;
            bad_q    <= ~ack_ok;
            diff_p_q <= (state_d == Assert);
            diff_n_q <= (state_d != Assert);
        end
    end

    assign diff_po      = diff_p_q;
    assign diff_no      = diff_n_q;
    assign busy_o       = (state_q != Idle);
    assign done_o       = done_q;
    assign pend_o       = pend_q;
    assign ovf_o        = ovf_q;
    assign ack_sigint_o = sigint_q;

endmodule

// File: tb/tb_diff_event_sender.sv
// Scoreboard bench for diff_event_sender: three configurations share one event stream,
// each with its own far-side ack responder and a transaction-level reference model.
module tb_diff_event_sender;
    localparam int NDut = 3;
    localparam bit AsyncCfg [NDut] = '{1'b0, 1'b0, 1'b1};
    localparam int MaxCfg   [NDut] = '{15, 3, 15};

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            event_i = 1'b0;
    logic [NDut-1:0] ack_p = '0;
    logic [NDut-1:0] ack_n = '1;
    logic [NDut-1:0] diff_p, diff_n, busy, done, ovf, sig;
    logic [3:0]      pend0;
    logic [1:0]      pend1;
    logic [3:0]      pend2;

    always #5 clk = ~clk;

    diff_event_sender u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .event_i(event_i), .ack_pi(ack_p[0]), .ack_ni(ack_n[0]),
        .diff_po(diff_p[0]), .diff_no(diff_n[0]), .busy_o(busy[0]), .done_o(done[0]),
        .pend_o(pend0), .ovf_o(ovf[0]), .ack_sigint_o(sig[0])
    );
    diff_event_sender #(.AsyncOn(1'b0), .MaxPend(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .event_i(event_i), .ack_pi(ack_p[1]), .ack_ni(ack_n[1]),
        .diff_po(diff_p[1]), .diff_no(diff_n[1]), .busy_o(busy[1]), .done_o(done[1]),
        .pend_o(pend1), .ovf_o(ovf[1]), .ack_sigint_o(sig[1])
    );
    diff_event_sender #(.AsyncOn(1'b1), .MaxPend(15)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .event_i(event_i), .ack_pi(ack_p[2]), .ack_ni(ack_n[2]),
        .diff_po(diff_p[2]), .diff_no(diff_n[2]), .busy_o(busy[2]), .done_o(done[2]),
        .pend_o(pend2), .ovf_o(ovf[2]), .ack_sigint_o(sig[2])
    );

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Reference model: wire level, return-to-zero flag, queue depth, bad-ack run length.
    bit m_out [NDut], m_ret [NDut], m_sig [NDut], m_done [NDut], m_ovf [NDut];
    int m_pend [NDut], m_bad [NDut];
    bit m_s1p [NDut], m_s2p [NDut], m_s1n [NDut], m_s2n [NDut];

    // Far-side responder loops the expected event wire back two cycles later.
    bit lb0 [NDut], lb1 [NDut], prev_lb [NDut];
    int fault_left = 0;
    bit hold_low = 1'b0;
    bit skew_on = 1'b0;

    logic [13:0] sb_q [NDut][$];
    int done_cnt [NDut], ovf_cnt [NDut], sig_cnt [NDut], busy_cnt [NDut], pk [NDut];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] act_vec(input int d);
        logic [7:0] p;
        case (d)
            0:       p = {4'h0, pend0};
            1:       p = {6'h0, pend1};
            default: p = {4'h0, pend2};
        endcase
        return {diff_p[d], diff_n[d], busy[d], done[d], ovf[d], sig[d], p};
    endfunction

    function automatic logic [13:0] exp_vec(input int d);
        return {m_out[d], !m_out[d], m_out[d] | m_ret[d], m_done[d], m_ovf[d], m_sig[d], 8'(m_pend[d])};
    endfunction

    function automatic void model_reset(input int d);
        m_out[d] = 0; m_ret[d] = 0; m_sig[d] = 0; m_done[d] = 0; m_ovf[d] = 0;
        m_pend[d] = 0; m_bad[d] = 0;
        m_s1p[d] = 0; m_s2p[d] = 0; m_s1n[d] = 1; m_s2n[d] = 1;
        lb0[d] = 0; lb1[d] = 0; prev_lb[d] = 0;
    endfunction

    function automatic void model_step(input int d, input bit ev, input bit ap, input bit an);
        bit ep, en, ok, lvl, go, idle, start, direct, inc, dec;
        ep = AsyncCfg[d] ? m_s2p[d] : ap;
        en = AsyncCfg[d] ? m_s2n[d] : an;
        ok = ep ^ en;
        lvl = ep;
        go = ok && !m_sig[d];
        idle = !m_out[d] && !m_ret[d];
        start = idle && go && !lvl && (ev || m_pend[d] > 0);
        m_done[d] = 0;
        if (start) m_out[d] = 1;
        else if (m_out[d] && go && lvl) begin m_out[d] = 0; m_ret[d] = 1; end
        else if (m_ret[d] && go && !lvl) begin m_ret[d] = 0; m_done[d] = 1; end
        direct = start && m_pend[d] == 0;
        inc = ev && !direct;
        dec = start && m_pend[d] > 0;
        m_ovf[d] = 0;
        if (inc && !dec) begin
            if (m_pend[d] == MaxCfg[d]) m_ovf[d] = 1;
            else m_pend[d]++;
        end else if (dec && !inc) begin
            m_pend[d]--;
        end
        m_bad[d] = ok ? 0 : m_bad[d] + 1;
        m_sig[d] = m_bad[d] >= (AsyncCfg[d] ? 2 : 1);
        m_s2p[d] = m_s1p[d]; m_s1p[d] = ap;
        m_s2n[d] = m_s1n[d]; m_s1n[d] = an;
    endfunction

    task automatic responder(input int d, output bit ap, output bit an);
        bit lb;
        lb = lb1[d];
        if (hold_low) begin ap = 0; an = 1; end
        else if (fault_left > 0) begin ap = 1; an = 1; end
        else begin ap = lb; an = skew_on ? !(lb && prev_lb[d]) : !lb; end
        prev_lb[d] = lb;
        lb1[d] = lb0[d];
        lb0[d] = m_out[d];
    endtask

    task automatic drive_cycle(input bit ev);
        bit ap, an;
        event_i = ev;
        for (int d = 0; d < NDut; d++) begin
            responder(d, ap, an);
            ack_p[d] = ap;
            ack_n[d] = an;
            model_step(d, ev, ap, an);
            sb_q[d].push_back(exp_vec(d));
        end
        if (fault_left > 0) fault_left--;
    endtask

    task automatic step(input bit ev);
        @(negedge clk);
        drive_cycle(ev);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic clear_counts();
        for (int d = 0; d < NDut; d++) begin
            done_cnt[d] = 0; ovf_cnt[d] = 0; sig_cnt[d] = 0; busy_cnt[d] = 0; pk[d] = 0;
        end
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        event_i = 1'b0;
        ack_p = '0;
        ack_n = '1;
        #1;
        for (int d = 0; d < NDut; d++) begin
            check($sformatf("reset_state_dut%0d", d), 32'(act_vec(d)), 32'(14'b01_0000_0000_0000));
            sb_q[d].delete();
            model_reset(d);
        end
        fault_left = 0;
        hold_low = 1'b0;
        skew_on = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b0);
        mon_en = 1'b1;
    endtask

    // Monitor: every cycle each DUT presents its outputs; compare against the oldest expectation.
    initial begin
        logic [13:0] e;
        logic [13:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                for (int d = 0; d < NDut; d++) begin
                    if (sb_q[d].size() != 0) begin
                        e = sb_q[d].pop_front();
                        a = act_vec(d);
                        check($sformatf("cycle_dut%0d", d), 32'(a), 32'(e));
                        done_cnt[d] += int'(done[d]);
                        ovf_cnt[d]  += int'(ovf[d]);
                        sig_cnt[d]  += int'(sig[d]);
                        busy_cnt[d] += int'(busy[d]);
                        if (int'(a[7:0]) > pk[d]) pk[d] = int'(a[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2;
        apply_reset();

        // Single event with loopback ack.
        clear_counts();
        step(1'b1);
        idle(14);
        check("single_done", done_cnt[0], 1);
        check("single_pend_peak", pk[0], 0);

        // Burst of five events while the first transfer is in flight.
        clear_counts();
        repeat (5) step(1'b1);
        idle(60);
        check("burst_done", done_cnt[0], 5);
        check("burst_pend_peak", pk[0], 4);
        check("burst_pend_end", 32'(pend0), 0);

        // Ack held low: queue saturates in the MaxPend=3 instance.
        clear_counts();
        hold_low = 1'b1;
        repeat (6) step(1'b1);
        idle(4);
        check("sat_pend_peak", pk[1], 3);
        check("sat_ovf_pulses", ovf_cnt[1], 2);
        check("sat_no_ovf_deep", ovf_cnt[0], 0);
        check("sat_pend_deep", 32'(pend0), 5);
        hold_low = 1'b0;
        idle(100);
        check("sat_drained", 32'(pend0), 0);

        // Ack pair forced to 1/1 for three cycles during Assert.
        clear_counts();
        step(1'b1);
        fault_left = 3;
        idle(20);
        check("fault_sigint_cycles", sig_cnt[0], 3);
        check("fault_done", done_cnt[0], 1);

        // One-cycle skew on the rising ack edge.
        clear_counts();
        skew_on = 1'b1;
        step(1'b1);
        idle(20);
        skew_on = 1'b0;
        check("skew_sigint_async", sig_cnt[2], 0);
        check("skew_done_async", done_cnt[2], 1);

        // Reset in the middle of Assert with two events queued.
        hold_low = 1'b1;
        repeat (3) step(1'b1);
        step(1'b0);
        #2;
        check("pre_reset_pend", 32'(pend0), 2);
        check("pre_reset_busy", 32'(busy[0]), 1);
        apply_reset();
        clear_counts();
        idle(15);
        check("post_reset_idle", busy_cnt[0], 0);

        // Randomized traffic with faults, skew and stalls.
        clear_counts();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                hold_low = ($urandom_range(0, 3) == 0);
                skew_on = $urandom_range(0, 1) == 1;
            end
            if (fault_left == 0 && $urandom_range(0, 99) < 3) fault_left = $urandom_range(1, 3);
            step($urandom_range(0, 99) < 35);
        end
        hold_low = 1'b0;
        skew_on = 1'b0;
        idle(200);
        check("random_drained", 32'(pend0), 0);

        @(posedge clk);
        #2;
        for (int d = 0; d < NDut; d++) check($sformatf("sb_empty_dut%0d", d), sb_q[d].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
